dac_spi_tx: RTL and testbench

- Output stage that takes stereo 16-bit samples from the additive oscillator core and drives the dual-channel SPI DAC on o_DAC_MOSI, o_DAC_SCK and o_DAC_CS.
- Each accepted sample pair becomes two 24-bit frames: channel A (load buffer), then channel B (load and update both outputs).
- Sits directly downstream of the sample mixer inside top.
- Runs on the 48 MHz i_Clock.

---
 rtl/dac_spi_pkg.sv | 24 ++
 rtl/dac_spi_tx_sck_tick_gen.sv | 23 ++
 rtl/dac_spi_tx.sv | 113 +++++++++++
 tb/tb_dac_spi_tx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared state encoding, frame geometry and default DAC command bytes.
package dac_spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP_A, SHIFT_A, GAP_A, SETUP_B, SHIFT_B, GAP_B} state_e;

    localparam int FRAME_BITS  = 24;
    localparam int SAMPLE_BITS = 16;

    localparam logic [7:0] CMD_A_DEF = 8'h10;
    localparam logic [7:0] CMD_B_DEF = 8'h24;

    function automatic logic cs_active(input state_e s);
        return s inside {SETUP_A, SHIFT_A, SETUP_B, SHIFT_B};
    endfunction

    function automatic logic in_shift(input state_e s);
        return s inside {SHIFT_A, SHIFT_B};
    endfunction

    function automatic logic chan_a(input state_e s);
        return s inside {SETUP_A, SHIFT_A, GAP_A};
    endfunction

endpackage

// File: rtl/dac_spi_tx_sck_tick_gen.sv
// sck_tick_gen: one-cycle tick every CLK_DIV clocks, restarted by load_i so each phase starts aligned.
module sck_tick_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic tick_o
);
    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb cnt_d = (load_i || cnt_q == 8'd0) ? RELOAD : cnt_q - 8'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = cnt_q == 8'd0;

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises a stereo 16-bit sample pair into two 24-bit SPI frames for a dual-channel DAC.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 4,
    parameter logic [7:0]  CMD_A   = CMD_A_DEF,
    parameter logic [7:0]  CMD_B   = CMD_B_DEF
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic [SAMPLE_BITS-1:0] i_Sample_L,
    input  logic [SAMPLE_BITS-1:0] i_Sample_R,
    input  logic                   i_Sample_Valid,
    output logic                   o_Ready,
    output logic                   o_Overrun,
    output logic                   o_DAC_MOSI,
    output logic                   o_DAC_SCK,
    output logic                   o_DAC_CS
);
    localparam logic [7:0] GAP_M1 = 8'(CS_GAP - 1);

    state_e                state_q, state_d;
    logic [4:0]            bit_q, bit_d, idx;
    logic                  hi_q, hi_d;
    logic [7:0]            gap_q, gap_d;
    logic [FRAME_BITS-1:0] frame_a_q, frame_a_d, frame_b_q, frame_b_d, frame_sel;
    logic                  cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d, ready_q, ready_d;
    logic                  tick;

    sck_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i  (i_Clock),
        .rst_i  (i_Reset),
        .load_i (state_d != state_q),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        hi_d      = hi_q;
        gap_d     = gap_q;
        frame_a_d = frame_a_q;
        frame_b_d = frame_b_q;
        unique case (state_q)
            IDLE: if (i_Sample_Valid) begin
                frame_a_d = {CMD_A, i_Sample_L};
                frame_b_d = {CMD_B, i_Sample_R};
                state_d   = SETUP_A;
            end
            SETUP_A, SETUP_B: if (tick) begin
                state_d = (state_q == SETUP_A) ? SHIFT_A : SHIFT_B;
                bit_d   = 5'(FRAME_BITS - 1);
                hi_d    = 1'b1;
            end
            SHIFT_A, SHIFT_B: if (tick) begin
                if (hi_q) hi_d = 1'b0;
                else if (bit_q == 5'd0) begin
                    state_d = (state_q == SHIFT_A) ? GAP_A : GAP_B;
                    gap_d   = GAP_M1;
                end else begin
                    bit_d = bit_q - 5'd1;
                    hi_d  = 1'b1;
                end
            end
            GAP_A, GAP_B: begin
                if (gap_q == 8'd0) state_d = (state_q == GAP_A) ? SETUP_B : IDLE;
                else gap_d = gap_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
        // Pins are computed from next-state values so they come straight out of flops.
        frame_sel = chan_a(state_d) ? frame_a_d : frame_b_d;
        idx       = in_shift(state_d) ? bit_d : 5'(FRAME_BITS - 1);
        cs_d      = !cs_active(state_d);
        sck_d     = in_shift(state_d) && hi_d;
        mosi_d    = cs_active(state_d) && frame_sel[idx];
        ready_d   = state_d == IDLE;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            bit_q     <= 5'd0;
            hi_q      <= 1'b0;
            gap_q     <= 8'd0;
            frame_a_q <= '0;
            frame_b_q <= '0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            hi_q      <= hi_d;
            gap_q     <= gap_d;
            frame_a_q <= frame_a_d;
            frame_b_q <= frame_b_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            ready_q   <= ready_d;
        end
    end

    assign o_Ready    = ready_q;
    assign o_Overrun  = i_Sample_Valid & ~ready_q & ~i_Reset;
    assign o_DAC_CS   = cs_q;
    assign o_DAC_SCK  = sck_q;
    assign o_DAC_MOSI = mosi_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: scoreboard bench for dac_spi_tx at default timing and at CLK_DIV=1/CS_GAP=1.
`timescale 1ns/1ps
module tb_dac_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] l[2], r[2];
    logic [1:0]  v, rst;
    wire  [1:0]  ready, ovr, mosi, sck, cs;

    int checks = 0, fails = 0, cyc = 0;
    bit armed = 1'b0;

    logic [23:0] q0[$], q1[$];
    int          busy_until[2], lacc[2], llen[2], hlen[2], nb[2];
    logic [23:0] sh[2];
    bit          coll[2], fidx[2], gap_ok[2];
    logic        pcs[2], psck[2], pmosi[2];

    dac_spi_tx u_dut0 (
        .i_Clock(clk), .i_Reset(rst[0]), .i_Sample_L(l[0]), .i_Sample_R(r[0]),
        .i_Sample_Valid(v[0]), .o_Ready(ready[0]), .o_Overrun(ovr[0]),
        .o_DAC_MOSI(mosi[0]), .o_DAC_SCK(sck[0]), .o_DAC_CS(cs[0])
    );

    dac_spi_tx #(.CLK_DIV(1), .CS_GAP(1)) u_dut1 (
        .i_Clock(clk), .i_Reset(rst[1]), .i_Sample_L(l[1]), .i_Sample_R(r[1]),
        .i_Sample_Valid(v[1]), .o_Ready(ready[1]), .o_Overrun(ovr[1]),
        .o_DAC_MOSI(mosi[1]), .o_DAC_SCK(sck[1]), .o_DAC_CS(cs[1])
    );

    function automatic int dv(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int gv(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Accept-to-ready distance: two frames of 49 half-SCK units each, plus gaps, plus the accept cycle.
    function automatic int ft(input int k);
        return 1 + 2 * (49 * dv(k) + gv(k));
    endfunction

    function automatic void chk(input bit ok, input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, k, $time, act, exp);
        end
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            busy_until[k] = 0; lacc[k] = 0; llen[k] = 0; hlen[k] = 0; nb[k] = 0; sh[k] = '0;
            coll[k] = 0; fidx[k] = 0; gap_ok[k] = 0; pcs[k] = 1'b1; psck[k] = 1'b0; pmosi[k] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                bit er, have;
                logic [23:0] expf;
                er = cyc >= busy_until[k];
                chk(ready[k] === er, "ready", k, 32'(ready[k]), 32'(er));
                chk(ovr[k] === (v[k] & ~er), "overrun", k, 32'(ovr[k]), 32'(v[k] & ~er));
                if (er)
                    chk(cs[k] === 1'b1 && sck[k] === 1'b0 && mosi[k] === 1'b0, "idle_pins", k,
                        {29'd0, cs[k], sck[k], mosi[k]}, 32'h4);
                if (cs[k] === 1'b1)
                    chk(sck[k] === 1'b0 && mosi[k] === 1'b0, "cs_high_pins", k, {30'd0, sck[k], mosi[k]}, 32'h0);
                chk(!(mosi[k] !== pmosi[k] && !(sck[k] && !psck[k]) && cs[k] === pcs[k]), "mosi_stable", k,
                    {30'd0, pmosi[k], mosi[k]}, {30'd0, pmosi[k], pmosi[k]});
                if (cs[k] === 1'b0) begin
                    if (pcs[k] === 1'b1) begin
                        if (fidx[k] && gap_ok[k]) chk(hlen[k] == gv(k), "cs_gap", k, hlen[k], gv(k));
                        if (!fidx[k]) chk(cyc == lacc[k] + 1, "cs_latency", k, cyc - lacc[k], 1);
                        coll[k] = 1; nb[k] = 0; sh[k] = '0; llen[k] = 0;
                    end
                    llen[k]++;
                    if (psck[k] === 1'b1 && sck[k] === 1'b0) begin
                        sh[k] = {sh[k][22:0], mosi[k]};
                        nb[k]++;
                    end
                end else begin
                    if (pcs[k] === 1'b0 && coll[k]) begin
                        chk(llen[k] == 49 * dv(k), "cs_low_len", k, llen[k], 49 * dv(k));
                        chk(nb[k] == 24, "bit_count", k, nb[k], 24);
                        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
                        if (have) begin
                            if (k == 0) expf = q0.pop_front();
                            else        expf = q1.pop_front();
                            chk(sh[k] == expf, "frame", k, {8'd0, sh[k]}, {8'd0, expf});
                        end else chk(1'b0, "frame_unexpected", k, {8'd0, sh[k]}, 0);
                        coll[k] = 0; fidx[k] = ~fidx[k]; gap_ok[k] = 1; hlen[k] = 0;
                    end
                    hlen[k]++;
                end
                if (v[k] && er) begin
                    if (k == 0) begin q0.push_back({8'h10, l[0]}); q0.push_back({8'h24, r[0]}); end
                    else        begin q1.push_back({8'h10, l[1]}); q1.push_back({8'h24, r[1]}); end
                    busy_until[k] = cyc + ft(k);
                    lacc[k] = cyc;
                end
                if (rst[k]) begin
                    if (k == 0) q0.delete(); else q1.delete();
                    busy_until[k] = cyc + 1;
                    coll[k] = 0; fidx[k] = 0; gap_ok[k] = 0;
                end
                pcs[k] = cs[k]; psck[k] = sck[k]; pmosi[k] = mosi[k];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (ready[k] !== 1'b1 && n < 2000) begin step(); n++; end
        if (ready[k] !== 1'b1) chk(1'b0, "send_timeout", k, n, 2000);
        l[k] = a; r[k] = b; v[k] = 1'b1;
        step();
        v[k] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ready !== 2'b11 && n < 3000) begin step(); n++; end
        if (ready !== 2'b11) chk(1'b0, "idle_timeout", 0, {30'd0, ready}, 32'h3);
        step();
    endtask

    initial begin
        rst = 2'b11; v = 2'b00;
        l[0] = 16'h0; l[1] = 16'h0; r[0] = 16'h0; r[1] = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 2'b00; armed = 1'b1;
        step(); step();
        fork
            send(0, 16'hA5C3, 16'h0F0F);
            send(1, 16'hFFFF, 16'h0000);
        join
        wait_idle();
        send(0, 16'h8000, 16'h0001);
        l[0] = 16'h1234;
        wait_idle();
        send(0, 16'(($urandom)), 16'(($urandom)));
        repeat (56) step();
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        repeat (20) step();
        send(0, 16'h3C5A, 16'hC3A5);
        wait_idle();
        fork
            begin
                v[0] = 1'b1;
                for (int i = 0; i < 1100; i++) begin l[0] = 16'(i * 3 + 1); r[0] = 16'(~i); step(); end
                v[0] = 1'b0;
            end
            begin
                v[1] = 1'b1;
                for (int i = 0; i < 600; i++) begin l[1] = 16'($urandom); r[1] = 16'($urandom); step(); end
                v[1] = 1'b0;
            end
        join
        wait_idle();
        fork
            for (int i = 0; i < 100; i++) begin
                send(0, 16'($urandom), 16'($urandom));
                repeat ($urandom_range(0, 3)) step();
            end
            for (int i = 0; i < 100; i++) begin
                send(1, 16'($urandom), 16'($urandom));
                repeat ($urandom_range(0, 3)) step();
            end
        join
        wait_idle();
        repeat (5) step();
        chk(q0.size() == 0, "q0_drained", 0, q0.size(), 0);
        chk(q1.size() == 0, "q1_drained", 1, q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
